bullet_controller: RTL

Sequences the single player bullet of the asteroids game: launches it from the ship on a fire press, advances it once per video frame, detects collision with the rock, and enforces hit-flash and cooldown periods. It sits between the input/game-tick logic and the pixel index selector, driving the `x_bullet`/`y_bullet` coordinates that the selector compares against each scan address. While no bullet is live, it parks the coordinates off-screen so the selector never paints the bullet.

---
 rtl/bullet_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bullet_controller.sv
// Player bullet sequencer for the asteroids game.
// Launches the bullet from the ship on a fire press, advances it upward once
// per frame, and parks it off-screen whenever no bullet is live. When the
// BULLET_HIT_EN macro is defined, it also detects collision with the rock,
// runs a hit-flash period and keeps a saturating score. Without the macro the
// bullet passes through the rock and the hit outputs stay at zero.
// Ports:
//   clock, resetn        : clock, asynchronous active-low reset
//   frame_tick           : one-cycle pulse per frame (vblank start)
//   fire                 : raw asynchronous fire button, high = pressed
//   x_ship, y_ship       : ship top-left corner
//   x_rock, y_rock       : rock top-left corner
//   x_bullet, y_bullet   : bullet top-left corner, or parked at (SCREEN_W, SCREEN_H)
//   bullet_active        : bullet in flight
//   hit_flash            : hit-flash period in progress
//   rock_hit             : one-cycle pulse after a colliding frame
//   score                : saturating hit count
module bullet_controller #(
   parameter int unsigned SCREEN_W        = 640,
   parameter int unsigned SCREEN_H        = 480,
   parameter int unsigned SHIP_W          = 100,
   parameter int unsigned BULLET_W        = 20,
   parameter int unsigned BULLET_H        = 20,
   parameter int unsigned ROCK_W          = 100,
   parameter int unsigned ROCK_H          = 100,
   parameter int unsigned SPEED           = 8,
   parameter int unsigned HIT_FRAMES      = 15,
   parameter int unsigned COOLDOWN_FRAMES = 10
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        frame_tick,
   input  logic        fire,
   input  logic [18:0] x_ship,
   input  logic [18:0] y_ship,
   input  logic [18:0] x_rock,
   input  logic [18:0] y_rock,
   output logic [18:0] x_bullet,
   output logic [18:0] y_bullet,
   output logic        bullet_active,
   output logic        hit_flash,
   output logic        rock_hit,
   output logic [15:0] score
);

   localparam int unsigned CW     = 19;
   localparam int unsigned COOL_N = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
   localparam logic [7:0]    COOL_LAST = 8'(COOL_N - 1);
   localparam logic [CW-1:0] PARK_X    = CW'(SCREEN_W);
   localparam logic [CW-1:0] PARK_Y    = CW'(SCREEN_H);
   localparam logic [CW-1:0] LAUNCH_DX = CW'((SHIP_W - BULLET_W) / 2);
   localparam logic [CW-1:0] BH        = CW'(BULLET_H);
   localparam logic [CW-1:0] STEP_Y    = CW'(SPEED);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FLY  = 2'd1,
      S_COOL = 2'd2
`ifdef BULLET_HIT_EN
      , S_HIT = 2'd3
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [CW-1:0] xb_q, xb_d, yb_q, yb_d;
   logic          pend_q, pend_d;
   logic          sync1_q, sync2_q, sync3_q;
   logic          active_q;
   logic          fire_rise;
   logic [CW-1:0] launch_x, launch_y;

   // Rising edge of the synchronized button; sync3_q holds the previous sample
   assign fire_rise = sync2_q & ~sync3_q;

   assign launch_x = x_ship + LAUNCH_DX;
   assign launch_y = (y_ship < BH) ? '0 : (y_ship - BH);

`ifdef BULLET_HIT_EN
   localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);

   logic        flash_q, rock_hit_q, hit_d;
   logic [15:0] score_q, score_d;
   logic        overlap;

   // Box overlap evaluated one bit wider so the right/bottom edges cannot wrap
   assign overlap = ({1'b0, xb_q} < ({1'b0, x_rock} + 20'(ROCK_W)))  &&
                    ({1'b0, x_rock} < ({1'b0, xb_q} + 20'(BULLET_W))) &&
                    ({1'b0, yb_q} < ({1'b0, y_rock} + 20'(ROCK_H)))  &&
                    ({1'b0, y_rock} < ({1'b0, yb_q} + 20'(BULLET_H)));
`else
   logic unused_rock;
   assign unused_rock = ^{x_rock, y_rock, 32'(HIT_FRAMES), 32'(ROCK_W), 32'(ROCK_H)};
`endif

   // Next-state: fire capture every cycle, everything else only on frame ticks
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xb_d    = xb_q;
      yb_d    = yb_q;
      pend_d  = pend_q;
`ifdef BULLET_HIT_EN
      hit_d   = 1'b0;
      score_d = score_q;
`endif
      // Presses while HIT/COOL are dropped; a press in FLY is cleared on COOL entry
      if (fire_rise && (state_q == S_IDLE || state_q == S_FLY)) pend_d = 1'b1;

      if (frame_tick) begin
         case (state_q)
            S_IDLE: begin
               if (pend_q || fire_rise) begin
                  state_d = S_FLY;
                  cnt_d   = '0;
                  xb_d    = launch_x;
                  yb_d    = launch_y;
                  pend_d  = 1'b0;
               end
            end
            S_FLY: begin
`ifdef BULLET_HIT_EN
               if (overlap) begin
                  state_d = S_HIT;
                  cnt_d   = '0;
                  xb_d    = PARK_X;
                  yb_d    = PARK_Y;
                  pend_d  = 1'b0;
                  hit_d   = 1'b1;
                  score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
               end else
`endif
               if (yb_q < STEP_Y) begin
                  state_d = S_COOL;
                  cnt_d   = '0;
                  xb_d    = PARK_X;
                  yb_d    = PARK_Y;
                  pend_d  = 1'b0;
               end else begin
                  yb_d = yb_q - STEP_Y;
               end
            end
`ifdef BULLET_HIT_EN
            S_HIT: begin
               if (cnt_q == HIT_LAST) begin
                  state_d = S_COOL;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
`endif
            S_COOL: begin
               if (cnt_q == COOL_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               xb_d    = PARK_X;
               yb_d    = PARK_Y;
            end
         endcase
      end
   end

   // State, synchronizer and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         xb_q       <= PARK_X;
         yb_q       <= PARK_Y;
         pend_q     <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         active_q   <= 1'b0;
`ifdef BULLET_HIT_EN
         flash_q    <= 1'b0;
         rock_hit_q <= 1'b0;
         score_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         xb_q       <= xb_d;
         yb_q       <= yb_d;
         pend_q     <= pend_d;
         sync1_q    <= fire;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         active_q   <= (state_d == S_FLY);
`ifdef BULLET_HIT_EN
         flash_q    <= (state_d == S_HIT);
         rock_hit_q <= hit_d;
         score_q    <= score_d;
`endif
      end
   end

   assign x_bullet      = xb_q;
   assign y_bullet      = yb_q;
   assign bullet_active = active_q;
`ifdef BULLET_HIT_EN
   assign hit_flash     = flash_q;
   assign rock_hit      = rock_hit_q;
   assign score         = score_q;
`else
   assign hit_flash     = 1'b0;
   assign rock_hit      = 1'b0;
   assign score         = '0;
`endif

endmodule
